accum_port_ctrl: RTL and testbench
==================================

ACCUM_PORT_CTRL -- requirements
Module: accum_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, array address width (depth 2^ADDR_W = 1024).
REQ-002 Parameter DATA_W, default 64, element and accumulator width, signed.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 r_enable  in  1  start pulse, sampled when state is IDLE.
REQ-006 init_i  in  ADDR_W  first element address.
REQ-007 init_acc  in  DATA_W  initial accumulator value.
REQ-008 len  in  ADDR_W+1  element count, 0..1024; values above 1024 treated as 1024.
REQ-009 w_enable  out  1  done pulse, one cycle.
REQ-010 result  out  DATA_W  final accumulator value, held until next start.
REQ-011 busy  out  1  high while the engine owns the memory port.
REQ-012 host_drop  out  1  one-cycle pulse when a host write is discarded.
REQ-013 controlArr  in  1  host requests the memory port.
REQ-014 controlArrWEnable_a, controlArrAddr_a, controlArrWData_a  in  1/ADDR_W/DATA_W  host write enable, address and write data.
REQ-015 controlArrRData_a  out  DATA_W  host read data, wired directly to memRData.
REQ-016 memWEnable, memAddr, memWData  out  1/ADDR_W/DATA_W  single-port RAM controls.
REQ-017 memRData  in  DATA_W  RAM read data, valid one cycle after address is presented.

Function
REQ-018 FSM states: IDLE, RD, WR, FIN.
REQ-019 In IDLE with r_enable=1, the block latches init_i into idx, init_acc into acc, and min(len,1024) into cnt; next state is RD if cnt>0, else FIN.
REQ-020 In RD: memAddr=idx and memWEnable=0; next state is WR.
REQ-021 In WR: acc <= acc+memRData, truncated mod 2^DATA_W with two's-complement wrap and no saturation.
REQ-022 In WR: memAddr=idx, memWData=acc+memRData, memWEnable=1.
REQ-023 In WR: idx increments mod 2^ADDR_W and cnt decrements; next state is RD if cnt>1, else FIN.
REQ-024 In FIN: w_enable=1 and result <= acc; next state is IDLE.
REQ-025 Latency: start sampled at cycle 0; element k read at cycle 1+2k and written at cycle 2+2k; w_enable at cycle 2N+1 (cycle 1 when N=0).
REQ-026 Port mux: in IDLE without a start, memory signals follow the controlArr* host inputs when controlArr=1.
REQ-027 Port mux: in IDLE with controlArr=0, memWEnable=0 and address/data are don't-care.
REQ-028 Port mux: when busy=1 (RD, WR, FIN, and the start cycle), the engine drives the port.
REQ-029 Start has priority over host: if r_enable=1 and controlArr=1 with controlArrWEnable_a=1 in IDLE, the host write is not performed and host_drop pulses that cycle.
REQ-030 Any host write presented while busy=1 is dropped and pulses host_drop.
REQ-031 Host reads while busy return whatever memRData carries; there is no guarantee of meaning.
REQ-032 r_enable while not IDLE is ignored; it is neither queued nor restarting.
REQ-033 Address wrap: init_i=1020 with len=8 processes addresses 1020..1023, then 0..3.
REQ-034 busy is combinational: high in the start cycle and in RD/WR/FIN, low otherwise.

Reset
REQ-035 rst=1 at a posedge forces state IDLE; acc, idx, cnt and result become 0; w_enable=0 and host_drop=0.
REQ-036 During reset, memWEnable=0 regardless of host inputs.
REQ-037 Reset mid-operation aborts without a further write; elements already written stay modified; no w_enable is issued.
REQ-038 rst has priority over r_enable in the same cycle.

Verification
REQ-039 Prefix-sum scenario: host loads mem[0..999] with random signed 32-bit values; start with init_i=0, init_acc=0, len=1000 -> mem[k] equals the running sum for every k, result equals the total, and w_enable comes exactly 2001 cycles after start.
REQ-040 Overflow scenario: mem[0]=0x7FFF_FFFF_FFFF_FFFF, mem[1]=1, init_acc=0, len=2 -> mem[1]=0x8000_0000_0000_0000 and result=0x8000_0000_0000_0000.
REQ-041 Wrap and empty scenario: init_i=1022, len=4, all elements 1, init_acc=5 -> mem[1022,1023,0,1]=6,7,8,9; then len=0, init_acc=-3 -> w_enable next cycle, result=-3, no memory write.
REQ-042 Conflict scenario: host write to addr 5 in the start cycle and during busy -> host_drop pulses each time and mem[5] is unchanged apart from the engine's own write.
REQ-043 Reset scenario: rst asserted at cycle 7 of a len=10 run -> mem[0..2] updated, mem[3..9] untouched, no w_enable; a rerun afterwards completes correctly.
REQ-044 Re-start scenario: r_enable pulsed at cycle 3 of a run -> no effect on cycle count or result.

Source files
------------

// File: rtl/accum_port_ctrl_if.sv
// Control, host and RAM-port signals of the accumulate engine.
// The engine connects through slave; the environment connects through master.
interface accum_port_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              r_enable;
  logic [ADDR_W-1:0] init_i;
  logic [DATA_W-1:0] init_acc;
  logic [ADDR_W:0]   len;
  logic              w_enable;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              host_drop;
  logic              controlArr;
  logic              controlArrWEnable_a;
  logic [ADDR_W-1:0] controlArrAddr_a;
  logic [DATA_W-1:0] controlArrWData_a;
  logic [DATA_W-1:0] controlArrRData_a;
  logic              memWEnable;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;

  modport slave (
    input  r_enable, init_i, init_acc, len,
    input  controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
    input  memRData,
    output w_enable, result, busy, host_drop, controlArrRData_a,
    output memWEnable, memAddr, memWData
  );

  modport master (
    output r_enable, init_i, init_acc, len,
    output controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
    output memRData,
    input  w_enable, result, busy, host_drop, controlArrRData_a,
    input  memWEnable, memAddr, memWData
  );
endinterface

// File: rtl/accum_port_ctrl.sv
// In-place prefix-sum engine over a single-port RAM: each element is read,
// added into the accumulator and written back, sharing the port with a host.
module accum_port_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input logic               clk,
  input logic               rst,
  accum_port_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              start;
  logic              busy;
  logic [ADDR_W:0]   len_clamp;
  logic [DATA_W-1:0] sum;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              w_en;

  // Reset outranks a start presented in the same cycle.
  assign start     = (state_q == IDLE) && bus.r_enable && !rst;
  assign busy      = (state_q != IDLE) || start;
  assign len_clamp = (bus.len > DEPTH) ? DEPTH : bus.len;
  assign sum       = acc_q + bus.memRData;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    mem_we    = 1'b0;
    mem_addr  = idx_q;
    mem_wdata = sum;
    w_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d    = bus.init_i;
          acc_d    = bus.init_acc;
          cnt_d    = len_clamp;
          mem_addr = bus.init_i;
          state_d  = (|len_clamp) ? RD : FIN;
        end else if (bus.controlArr) begin
          mem_we    = bus.controlArrWEnable_a;
          mem_addr  = bus.controlArrAddr_a;
          mem_wdata = bus.controlArrWData_a;
        end
      end
      RD: state_d = WR;
      WR: begin
        mem_we  = 1'b1;
        acc_d   = sum;
        idx_d   = idx_q + ADDR_W'(1);
        cnt_d   = cnt_q - (ADDR_W+1)'(1);
        state_d = (cnt_q > (ADDR_W+1)'(1)) ? RD : FIN;
      end
      FIN: begin
        w_en     = 1'b1;
        result_d = acc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must never disturb memory or signal completion.
    if (rst) begin
      mem_we = 1'b0;
      w_en   = 1'b0;
    end
  end

  assign bus.memWEnable        = mem_we;
  assign bus.memAddr           = mem_addr;
  assign bus.memWData          = mem_wdata;
  assign bus.w_enable          = w_en;
  assign bus.result            = result_q;
  assign bus.busy              = busy;
  assign bus.host_drop         = bus.controlArr && bus.controlArrWEnable_a && busy && !rst;
  assign bus.controlArrRData_a = bus.memRData;
endmodule

// File: tb/tb_accum_port_ctrl.sv
// Directed bench: behavioural RAM, a reference memory image and a scoreboard of
// expected results and completion latencies checked when the engine finishes.
module tb_accum_port_ctrl;
  logic clk, rst;
  int   n_tests, n_fail;

  logic [63:0] ram   [1024];
  logic [63:0] model [1024];
  logic [63:0] exp_res_q [$];
  int          exp_lat_q [$];

  accum_port_ctrl_if #(.ADDR_W(10), .DATA_W(64)) bus ();
  accum_port_ctrl #(.ADDR_W(10), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.memWEnable) ram[bus.memAddr] <= bus.memWData;
    bus.memRData <= ram[bus.memAddr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [9:0] a, input logic [63:0] d);
    @(negedge clk);
    bus.controlArr = 1'b1; bus.controlArrWEnable_a = 1'b1;
    bus.controlArrAddr_a = a; bus.controlArrWData_a = d;
    model[a] = d;
  endtask

  task automatic check_mem(input logic [9:0] a, input string tag);
    @(negedge clk);
    bus.controlArr = 1'b1; bus.controlArrWEnable_a = 1'b0; bus.controlArrAddr_a = a;
    @(negedge clk);
    check(tag, bus.controlArrRData_a, model[a]);
    bus.controlArr = 1'b0;
  endtask

  task automatic run(input logic [9:0] ii, input logic [63:0] ia, input logic [10:0] ln,
                     input bit conflict, input int restart_at, input int reset_at);
    int n, k, lim, lat;
    logic [9:0]  a;
    logic [63:0] s, er;
    bit done;
    n = (ln > 11'd1024) ? 1024 : int'(ln);
    a = ii; s = ia;
    for (int e = 0; e < n; e++) begin
      if (reset_at == 0 || 2 + 2*e < reset_at) begin
        s = s + model[a];
        model[a] = s;
      end
      a = a + 10'd1;
    end
    if (reset_at == 0) begin
      exp_res_q.push_back(s);
      exp_lat_q.push_back(2*n + 1);
    end
    @(negedge clk);
    rst = 1'b0; bus.r_enable = 1'b1;
    bus.init_i = ii; bus.init_acc = ia; bus.len = ln;
    bus.controlArr = conflict; bus.controlArrWEnable_a = conflict;
    bus.controlArrAddr_a = 10'd5; bus.controlArrWData_a = 64'hDEAD_BEEF;
    #1;
    check("busy_start", {63'd0, bus.busy}, 64'd1);
    check("drop_start", {63'd0, bus.host_drop}, {63'd0, conflict});
    @(negedge clk);
    k = 1; done = 1'b0;
    lim = (reset_at != 0) ? reset_at + 4 : 2*n + 5;
    while (!done && k <= lim) begin
      bus.controlArr = 1'b0; bus.controlArrWEnable_a = 1'b0; bus.r_enable = 1'b0; rst = 1'b0;
      if (conflict && k == 2) begin
        bus.controlArr = 1'b1; bus.controlArrWEnable_a = 1'b1;
        #1 check("drop_busy", {63'd0, bus.host_drop}, 64'd1);
      end
      if (k == restart_at) bus.r_enable = 1'b1;
      if (k == reset_at) rst = 1'b1;
      if (bus.w_enable) done = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    bus.controlArr = 1'b0; bus.controlArrWEnable_a = 1'b0; bus.r_enable = 1'b0; rst = 1'b0;
    if (reset_at != 0) begin
      check("no_done_after_rst", {63'd0, done}, 64'd0);
      check("result_after_rst", bus.result, 64'd0);
    end else begin
      check("done_seen", {63'd0, done}, 64'd1);
      if (done) begin
        lat = exp_lat_q.pop_front();
        er  = exp_res_q.pop_front();
        check("latency", 64'(k), 64'(lat));
        @(negedge clk);
        check("w_enable_pulse", {63'd0, bus.w_enable}, 64'd0);
        check("result", bus.result, er);
      end
    end
  endtask

  initial begin
    logic signed [31:0] r;
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    bus.r_enable = 1'b0; bus.init_i = '0; bus.init_acc = '0; bus.len = '0;
    bus.controlArr = 1'b1; bus.controlArrWEnable_a = 1'b1;
    bus.controlArrAddr_a = 10'd7; bus.controlArrWData_a = 64'h1234;
    @(negedge clk); @(negedge clk);
    check("rst_mem_we", {63'd0, bus.memWEnable}, 64'd0);
    check("rst_w_enable", {63'd0, bus.w_enable}, 64'd0);
    check("rst_host_drop", {63'd0, bus.host_drop}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_result", bus.result, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 1024; i++) host_write(10'(i), 64'd0);
    for (int i = 0; i < 1000; i++) begin
      r = $urandom();
      host_write(10'(i), {{32{r[31]}}, r});
    end
    run(10'd0, 64'd0, 11'd1000, 1'b0, 0, 0);
    for (int i = 0; i < 1000; i++) check_mem(10'(i), "prefix_mem");

    host_write(10'd0, 64'h7FFF_FFFF_FFFF_FFFF);
    host_write(10'd1, 64'd1);
    run(10'd0, 64'd0, 11'd2, 1'b0, 0, 0);
    check_mem(10'd1, "overflow_mem1");
    check("overflow_mem1_abs", model[1], 64'h8000_0000_0000_0000);

    host_write(10'd1022, 64'd1); host_write(10'd1023, 64'd1);
    host_write(10'd0, 64'd1);    host_write(10'd1, 64'd1);
    host_write(10'd2, 64'd77);
    run(10'd1022, 64'd5, 11'd4, 1'b0, 0, 0);
    check_mem(10'd1022, "wrap_1022"); check_mem(10'd1023, "wrap_1023");
    check_mem(10'd0, "wrap_0");       check_mem(10'd1, "wrap_1");
    check_mem(10'd2, "wrap_2_untouched");
    run(10'd1022, 64'hFFFF_FFFF_FFFF_FFFD, 11'd0, 1'b0, 0, 0);
    check_mem(10'd1022, "empty_1022"); check_mem(10'd1, "empty_1");

    host_write(10'd4, 64'd1); host_write(10'd5, 64'd100); host_write(10'd6, 64'd2);
    run(10'd4, 64'd0, 11'd3, 1'b1, 0, 0);
    check_mem(10'd4, "conflict_4"); check_mem(10'd5, "conflict_5"); check_mem(10'd6, "conflict_6");

    for (int i = 0; i < 10; i++) host_write(10'(i), 64'(i + 1));
    run(10'd0, 64'd0, 11'd10, 1'b0, 0, 7);
    for (int i = 0; i < 10; i++) check_mem(10'(i), "reset_mem");
    run(10'd0, 64'd0, 11'd10, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) check_mem(10'(i), "rerun_mem");

    for (int i = 20; i < 25; i++) host_write(10'(i), 64'(3 * i));
    run(10'd20, 64'd9, 11'd5, 1'b0, 3, 0);
    check_mem(10'd24, "restart_24");

    run(10'd0, 64'd0, 11'd2047, 1'b0, 0, 0);
    check_mem(10'd1023, "clamp_1023");
    check_mem(10'd0, "clamp_0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
